// File: rtl/expr_emitter.sv
// ============================================================================
// expr_emitter : serialises a stored "digit (op digit)*" expression to ASCII
// Rev 1.0
// ============================================================================
`default_nettype none

module expr_emitter #(
    parameter int MAX_TERMS = 4,
    localparam int OPS_W    = (MAX_TERMS > 1) ? MAX_TERMS - 1 : 1
) (
    input  logic                   clk,
    input  logic                   clr_n,
    input  logic                   start,
    input  logic [2:0]             n_terms,
    input  logic [4*MAX_TERMS-1:0] digits,
    input  logic [OPS_W-1:0]       ops,
    output logic [7:0]             out_ch,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIG  = 2'd1,
        OP   = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [2:0] MAX_N = 3'(MAX_TERMS);

    state_t                 state, state_nx;
    logic [2:0]             idx;
    logic [2:0]             sh_n;
    logic [4*MAX_TERMS-1:0] sh_digits;
    logic [OPS_W-1:0]       sh_ops;
    logic                   err_r;
    logic                   req_ok;
    logic                   load;
    logic                   adv;
    logic [3:0]             cur_digit;
    logic                   cur_op;

    // Request is legal only if the count is in range and every used digit is 0..9
    always_comb begin
        req_ok = (n_terms != 3'd0) && (n_terms <= MAX_N);
        for (int i = 0; i < MAX_TERMS; i++) begin
            if ((3'(i) < n_terms) && (digits[4*i +: 4] > 4'd9)) begin
                req_ok = 1'b0;
            end
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        adv      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (req_ok) begin
                        state_nx = DIG;
                        load     = 1'b1;
                    end else begin
                        state_nx = FIN;
                    end
                end
            end
            DIG: begin
                if (out_rdy) begin
                    state_nx = (idx == sh_n - 3'd1) ? FIN : OP;
                end
            end
            OP: begin
                if (out_rdy) begin
                    state_nx = DIG;
                    adv      = 1'b1;
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            idx       <= 3'd0;
            sh_n      <= 3'd0;
            sh_digits <= '0;
            sh_ops    <= '0;
            err_r     <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                err_r <= ~req_ok;
            end
            if (load) begin
                idx       <= 3'd0;
                sh_n      <= n_terms;
                sh_digits <= digits;
                sh_ops    <= ops;
            end else if (adv) begin
                idx <= idx + 3'd1;
            end
        end
    end

    // Explicit mux keeps the shadow select free of variable-width index arithmetic
    always_comb begin
        cur_digit = 4'd0;
        cur_op    = 1'b0;
        for (int i = 0; i < MAX_TERMS; i++) begin
            if (idx == 3'(i)) begin
                cur_digit = sh_digits[4*i +: 4];
            end
        end
        for (int i = 0; i < MAX_TERMS - 1; i++) begin
            if (idx == 3'(i)) begin
                cur_op = sh_ops[i];
            end
        end
    end

    always_comb begin
        out_vld = 1'b0;
        out_ch  = 8'h00;
        case (state)
            DIG: begin
                out_vld = 1'b1;
                out_ch  = 8'h30 + {4'd0, cur_digit};
            end
            OP: begin
                out_vld = 1'b1;
                out_ch  = cur_op ? 8'h2A : 8'h2B;
            end
            default: begin
                out_vld = 1'b0;
                out_ch  = 8'h00;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == FIN);
    assign err  = err_r;

endmodule

`default_nettype wire

// File: doc/expr_emitter.md
# expr_emitter

Serialises a stored arithmetic expression into a stream of 8-bit ASCII characters, one character per accepted handshake. The output has the form digit (op digit)*, for example "1+3*2". It is the transmit-side counterpart of the expression-string recogniser. Its output stream feeds that recogniser's `in` port directly, or a UART/console path.

## Interface
Parameters:
- `MAX_TERMS`, default 4: maximum number of digits per expression. Legal range 1..7.

Ports:
- `clk`  in  1  system clock. All state changes on the rising edge.
- `clr_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request to emit the expression. Sampled only in IDLE.
- `n_terms`  in  3  number of digits to emit. Legal range 1..`MAX_TERMS`.
- `digits`  in  4*`MAX_TERMS`  digit i is `digits[4i+3:4i]`. Legal values 0..9.
- `ops`  in  `MAX_TERMS`-1 (minimum 1)  op i sits between digit i and digit i+1. 0 = '+' (8'h2B), 1 = '*' (8'h2A).
- `out_ch`  out  8  current ASCII character.
- `out_vld`  out  1  `out_ch` is valid.
- `out_rdy`  in  1  sink accepts `out_ch` this cycle.
- `busy`  out  1  an expression is in progress.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  the last `start` was rejected. Sticky until the next accepted `start`.

## Operation
- States: IDLE, DIG, OP, FIN.
- Outputs are Moore-decoded from registered state and shadow registers. There is no combinational path from any input to any output.
- IDLE, on `start`=1:
  - Validate the request. It is rejected if `n_terms`==0, or `n_terms`>`MAX_TERMS`, or any digit i < `n_terms` is greater than 9.
  - Rejected: set `err`=1, go to FIN, emit no characters.
  - Accepted: clear `err`; latch `n_terms`, `digits` and `ops` into shadow registers; clear index `idx` to 0; go to DIG.
  - Inputs are don't-care after the start edge.
- DIG:
  - `out_vld`=1, `out_ch` = 8'h30 + shadow digit[`idx`].
  - On `out_rdy`: go to FIN if `idx`==n_terms-1, otherwise go to OP.
- OP:
  - `out_vld`=1, `out_ch` = 8'h2B or 8'h2A according to shadow op[`idx`].
  - On `out_rdy`: `idx`++ and go to DIG.
- FIN: `done`=1 for exactly one cycle, then go to IDLE.
- `busy`=1 in DIG, OP and FIN. `busy`=0 in IDLE.
- `start` is ignored while `busy`=1. The shadow registers are not disturbed.
- Handshake rules:
  - A transfer occurs on a rising edge where `out_vld` && `out_rdy`.
  - While `out_vld`=1 and `out_rdy`=0, `out_ch` must hold stable.
  - `out_vld` never drops without a transfer, except on reset.
- `out_ch`=8'h00 whenever `out_vld`=0.
- `idx` width is 3 bits and never exceeds n_terms-1.

## Timing
- Reset values: state IDLE; `out_vld`=0, `out_ch`=8'h00, `busy`=0, `done`=0, `err`=0; `idx`=0.
  - Reset applies asynchronously on `clr_n` falling.
  - Release is synchronous to `clk`.
- Reset mid-stream: the partial expression is abandoned. `out_vld` and `busy` go to 0 without waiting for `clk`. No `done` is produced.
- Latency (start sampled on edge t):
  - First character is valid in the cycle after edge t.
  - With `out_rdy` held at 1, the 2n-1 characters appear on consecutive cycles t+1 .. t+2n-1.
  - `done` is high in cycle t+2n.
  - `busy` is low from cycle t+2n+1.
- Rejected start at edge t: `err`=1 and `done`=1 in cycle t+1; IDLE in cycle t+2. `out_vld` stays 0 throughout.
- Back-to-back: a new `start` is accepted at the earliest in the cycle after `done`.
- A `start` that coincides with `done` is ignored.

## Test plan
- Basic stream: `n_terms`=3, digits 1,3,2, ops 0,1, `out_rdy`=1. Expect "1","+","3","*","2" (8'h31,2B,33,2A,32) on 5 consecutive cycles, `done` on the 6th cycle, and `busy` high for 6 cycles.
- Backpressure: same stream with `out_rdy`=0 for 3 cycles while "+" is presented. Expect `out_ch` to hold at 8'h2B with `out_vld`=1, no skipped or duplicated characters, and `done` delayed by exactly 3 cycles.
- Single term: `n_terms`=1, digit 7. Expect exactly one transfer of 8'h37, then `done`. No operator is emitted.
- Rejection: digit1=10 with `n_terms`=2, then separately `n_terms`=0. Expect `err`=1 and a `done` pulse one cycle after start, with `out_vld` never asserted. A following valid start clears `err`.
- Reset mid-stream: drop `clr_n` after "3" is transferred. Expect `out_vld`, `busy` and `err` at 0 immediately and no `done`. After release, a `start` with digits 4,5 and op 0 yields "4+5" cleanly.
- Start while busy: pulse `start` with different operands during DIG. Expect the original stream to complete unchanged with a single `done`.
